// File: rtl/car_game_pkg.sv
// Shared screen geometry, sprite size and redraw state encoding for the car game video path.
package car_game_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int SPRITE_DIM = 8;

  localparam logic [2:0] DEFAULT_TRANSPARENT = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } redraw_state_e;

endpackage

// File: rtl/sprite_redraw_if.sv
// Request, ROM and VGA pixel-port signals of the sprite redraw engine.
interface sprite_redraw_if;

  logic        Req;
  logic [7:0]  NewX;
  logic [6:0]  NewY;
  logic        Busy;
  logic        Done;
  logic [5:0]  SprAddr;
  logic [2:0]  SprColour;
  logic [14:0] BgAddr;
  logic [2:0]  BgColour;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [2:0]  Colour;
  logic        Plot;

  // The master is the requester, which also models the external ROMs and the VGA adapter.
  modport master (
    output Req, NewX, NewY, SprColour, BgColour,
    input  Busy, Done, SprAddr, BgAddr, VGA_X, VGA_Y, Colour, Plot
  );

  modport slave (
    input  Req, NewX, NewY, SprColour, BgColour,
    output Busy, Done, SprAddr, BgAddr, VGA_X, VGA_Y, Colour, Plot
  );

endinterface

// File: rtl/sprite_scan.sv
// Row-major col/row scan over the 8x8 sprite, with a flag on the final pixel.
module sprite_scan
  import car_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  localparam logic [2:0] MAX_IDX = 3'(SPRITE_DIM - 1);

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (enable) begin
      col_d = col_q + 3'd1;
      if (col_q == MAX_IDX) begin
        row_d = row_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == MAX_IDX) && (col_q == MAX_IDX);

endmodule

// File: rtl/sprite_redraw.sv
// Moves the car sprite: erases the old 8x8 footprint from the background ROM, then draws
// the sprite at the new position, one pixel per cycle behind a one-cycle ROM latency.
module sprite_redraw
  import car_game_pkg::*;
#(
  parameter logic [2:0] TRANSPARENT = DEFAULT_TRANSPARENT,
  parameter int         BG_WIDTH    = SCREEN_W
) (
  input logic            Clock,
  input logic            Reset,
  sprite_redraw_if.slave bus
);

  redraw_state_e state_q, state_d;

  logic [7:0] new_x_q, new_x_d;
  logic [6:0] new_y_q, new_y_d;
  logic [7:0] old_x_q, old_x_d;
  logic [6:0] old_y_q, old_y_d;
  logic       old_valid_q, old_valid_d;

  logic       pix_valid_q, pix_valid_d;
  logic       pix_erase_q, pix_erase_d;
  logic       pix_in_q, pix_in_d;
  logic [7:0] pix_x_q, pix_x_d;
  logic [6:0] pix_y_q, pix_y_d;

  logic [2:0] row, col;
  logic       last;
  logic       scan_clear, scan_en;

  logic       erasing, issuing;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       in_bounds;

  sprite_scan u_scan (
    .clk    (Clock),
    .rst    (Reset),
    .clear  (scan_clear),
    .enable (scan_en),
    .row    (row),
    .col    (col),
    .last   (last)
  );

  always_comb begin
    state_d     = state_q;
    new_x_d     = new_x_q;
    new_y_d     = new_y_q;
    old_x_d     = old_x_q;
    old_y_d     = old_y_q;
    old_valid_d = old_valid_q;
    scan_clear  = 1'b0;
    scan_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        scan_clear = 1'b1;
        if (bus.Req) begin
          new_x_d = bus.NewX;
          new_y_d = bus.NewY;
          state_d = old_valid_q ? ST_ERASE : ST_DRAW;
        end
      end
      ST_ERASE: begin
        scan_en = 1'b1;
        if (last) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        scan_en = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        scan_clear  = 1'b1;
        old_x_d     = new_x_q;
        old_y_d     = new_y_q;
        old_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sums are one bit wider than the screen coordinates so the clip test sees overflow past the edge.
  always_comb begin
    erasing   = (state_q == ST_ERASE);
    issuing   = erasing || (state_q == ST_DRAW);
    base_x    = erasing ? old_x_q : new_x_q;
    base_y    = erasing ? old_y_q : new_y_q;
    sum_x     = {1'b0, base_x} + {6'd0, col};
    sum_y     = {1'b0, base_y} + {5'd0, row};
    in_bounds = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));

    pix_valid_d = issuing;
    pix_erase_d = erasing;
    pix_in_d    = in_bounds;
    pix_x_d     = issuing ? sum_x[7:0] : pix_x_q;
    pix_y_d     = issuing ? sum_y[6:0] : pix_y_q;
  end

  assign bus.SprAddr = (state_q == ST_DRAW) ? {row, col} : 6'd0;
  assign bus.BgAddr  = erasing ? 15'(15'(sum_y) * 15'(BG_WIDTH) + 15'(sum_x)) : 15'd0;

  assign bus.Busy   = (state_q != ST_IDLE);
  assign bus.Done   = (state_q == ST_DONE);
  assign bus.VGA_X  = pix_x_q;
  assign bus.VGA_Y  = pix_y_q;
  // ROM data arrives in the same cycle as the registered pixel, so colour is muxed combinationally.
  assign bus.Colour = !pix_valid_q ? 3'd0 : (pix_erase_q ? bus.BgColour : bus.SprColour);
  assign bus.Plot   = pix_valid_q && pix_in_q && (pix_erase_q || (bus.SprColour != TRANSPARENT));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      new_x_q     <= '0;
      new_y_q     <= '0;
      old_x_q     <= '0;
      old_y_q     <= '0;
      old_valid_q <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_erase_q <= 1'b0;
      pix_in_q    <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      new_x_q     <= new_x_d;
      new_y_q     <= new_y_d;
      old_x_q     <= old_x_d;
      old_y_q     <= old_y_d;
      old_valid_q <= old_valid_d;
      pix_valid_q <= pix_valid_d;
      pix_erase_q <= pix_erase_d;
      pix_in_q    <= pix_in_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
    end
  end

endmodule

// File: doc/sprite_redraw.md
SPRITE_REDRAW -- requirements
Module: sprite_redraw

Interface
REQ-001 Parameter TRANSPARENT, 3'b000: sprite colour that is never plotted.
REQ-002 Parameter BG_WIDTH, 160: screen width used for background ROM addressing.
REQ-003 Clock  in  1  system clock (50 MHz); all logic on the rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Req  in  1  request to move the car sprite to (NewX,NewY); sampled only in IDLE.
REQ-006 NewX  in  8  new sprite top-left x (0..159).
REQ-007 NewY  in  7  new sprite top-left y (0..119).
REQ-008 Busy  out  1  high whenever the state is not IDLE.
REQ-009 Done  out  1  one-cycle pulse when a redraw completes.
REQ-010 SprAddr  out  6  sprite ROM address {row[2:0],col[2:0]}.
REQ-011 SprColour  in  3  sprite ROM data, valid one cycle after SprAddr.
REQ-012 BgAddr  out  15  background ROM address, (y*BG_WIDTH + x).
REQ-013 BgColour  in  3  background ROM data, valid one cycle after BgAddr.
REQ-014 VGA_X  out  8, VGA_Y  out  7, Colour  out  3, Plot  out  1: pixel write port to vga_adapter.

Function
REQ-015 States SHALL be IDLE, ERASE, DRAW and DONE.
REQ-016 In IDLE with Req=1, NewX/NewY SHALL be latched; the next state is ERASE if an old position is valid, else DRAW.
REQ-017 ERASE and DRAW SHALL each issue 64 addresses, one per cycle, row-major (col 0..7 inner, row 0..7 outer).
REQ-018 ERASE SHALL address the background ROM at (OldY+row)*160+(OldX+col); the output colour is BgColour.
REQ-019 DRAW SHALL address the sprite ROM at {row,col}; the output colour is SprColour, with the pixel at (NewX+col, NewY+row).
REQ-020 The pixel for an address issued in cycle n SHALL appear on VGA_X/VGA_Y/Colour/Plot in cycle n+1, with a registered pipeline stage aligned to the ROM latency.
REQ-021 Plot SHALL be 0 for DRAW pixels whose SprColour equals TRANSPARENT.
REQ-022 Plot SHALL be 0 for any pixel with x+col > 159 or y+row > 119.
REQ-023 Coordinate sums SHALL be computed at 9/8 bits so that the clip test in REQ-022 does not wrap.
REQ-024 After the last DRAW address, the state SHALL enter DONE for exactly one cycle: Done=1, then IDLE.
REQ-025 In DONE, OldX/OldY SHALL take the latched new position, and old-valid SHALL be set.
REQ-026 Timing with Req accepted in cycle 0 and old position valid: ERASE addresses in cycles 1..64, DRAW addresses in cycles 65..128, pixels in cycles 2..129, Done in cycle 129, Busy high in cycles 1..129.
REQ-027 On the first draw (ERASE skipped): addresses in cycles 1..64, pixels in cycles 2..65, Done in cycle 65.
REQ-028 Req while Busy SHALL be ignored; there is no queueing.
REQ-029 Req to the current position SHALL still perform the full erase-and-draw.
REQ-030 Plot SHALL be 0 in IDLE, and in the first address cycle of each redraw before pipeline data is valid.

Reset
REQ-031 On Reset=1 at a clock edge: state=IDLE, Busy=0, Done=0, Plot=0, VGA_X=0, VGA_Y=0, Colour=0, SprAddr=0, BgAddr=0, row/col counters=0, old-valid=0.
REQ-032 Reset mid-redraw SHALL abort with no further Plot pulses; the next Req is treated as a first draw (no erase).

Structure
REQ-033 Package car_game_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, SPRITE_DIM=8, the state encoding and the TRANSPARENT default.
REQ-034 One sub-module, sprite_scan, SHALL provide the 3-bit col/row counters, clear/enable inputs and a last-pixel flag (row=7, col=7).
REQ-035 The sprite and background ROMs SHALL be external to this block.

Verification
REQ-036 Reset, then Req at (75,70) with a sprite ROM holding no transparent pixels -> 64 Plot pulses covering x 75..82, y 70..77, Done in cycle 65, no erase.
REQ-037 Second Req at (40,70) -> 64 background pixels at x 75..82 using BgAddr=(70+row)*160+75+col, then 64 sprite pixels at x 40..47, Done in cycle 129.
REQ-038 Req at (155,115) -> Plot only for x 155..159 and y 115..119 (25 pixels), with no wrap to x 0.
REQ-039 Sprite ROM with a transparent border -> 36 Plot pulses during DRAW.
REQ-040 Req pulsed again in cycle 30 of a redraw -> ignored, and exactly one Done occurs.
REQ-041 Reset asserted in cycle 40 of ERASE -> Plot=0 from the next cycle, and the following Req produces no ERASE phase.
